reduce_n_way: RTL and testbench

REDUCE_N_WAY -- requirements
Module: reduce_n_way

---
 rtl/reduce_pkg.sv | 17 +
 rtl/reduce_chunk.sv | 29 ++
 rtl/reduce_n_way.sv | 108 ++++++++++
 tb/tb_reduce_n_way.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// rtl/reduce_pkg.sv - shared mode and state encodings for the n-way reducer
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR   = 2'b00,
    MODE_AND  = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/reduce_chunk.sv
// rtl/reduce_chunk.sv - combinational reduction of one chunk plus its lowest set bit
module reduce_chunk
  import reduce_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter int LW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic [1:0]       mode,
  output logic             res,
  output logic             has_set,
  output logic [LW-1:0]    low_idx
);

  always_comb begin
    has_set = |chunk;
    low_idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) low_idx = LW'(i);
    end
    case (mode_e'(mode))
      MODE_AND: res = &chunk;
      MODE_XOR: res = ^chunk;
      default:  res = |chunk;
    endcase
  end

endmodule

// File: rtl/reduce_n_way.sv
// rtl/reduce_n_way.sv - multi-cycle OR/AND/XOR reducer consuming CHUNK bits per cycle
module reduce_n_way
  import reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] op;
  mode_e            mode_q;
  logic             acc, acc_nxt, found;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] cur;
  logic             c_res, c_set;
  logic [LW-1:0]    c_idx;
  logic             last, accept;

  assign cur    = op[cnt*CHUNK +: CHUNK];
  assign last   = (cnt == CW'(N - 1));
  assign accept = in_valid && in_ready;

  reduce_chunk #(.CHUNK(CHUNK), .LW(LW)) u_chunk (
    .chunk   (cur),
    .mode    (mode_q),
    .res     (c_res),
    .has_set (c_set),
    .low_idx (c_idx)
  );

  always_comb begin
    case (mode_q)
      MODE_AND: acc_nxt = acc & c_res;
      MODE_XOR: acc_nxt = acc ^ c_res;
      default:  acc_nxt = acc | c_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      mode_q <= MODE_OR;
      acc    <= 1'b0;
      found  <= 1'b0;
      cnt    <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      op     <= in;
      mode_q <= mode_e'(mode);
      acc    <= (mode_e'(mode) == MODE_AND);
      found  <= 1'b0;
      cnt    <= '0;
      idx_q  <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      // Only the first chunk with a set bit contributes the index.
      if (!found && c_set) begin
        found <= 1'b1;
        idx_q <= IW'(cnt * CHUNK) + IW'(c_idx);
      end
    end
  end

  assign out     = acc;
  assign out_idx = idx_q;

endmodule

// File: tb/tb_reduce_n_way.sv
// tb/tb_reduce_n_way.sv - randomized self-checking bench for reduce_n_way (8/2 and 8/8)
module tb_reduce_n_way;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din[2];
  logic [1:0] mode[2];
  logic       in_valid[2], in_ready[2], outv[2], out_valid[2], out_ready[2];
  logic [2:0] out_idx[2];
  int         tests = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  reduce_n_way #(.WIDTH(8), .CHUNK(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(din[0]), .mode(mode[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out(outv[0]), .out_idx(out_idx[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  reduce_n_way #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(din[1]), .mode(mode[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out(outv[1]), .out_idx(out_idx[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_model(input logic [7:0] v, input logic [1:0] m,
                                    output logic o, output logic [2:0] idx);
    case (m)
      2'b01:   o = &v;
      2'b10:   o = ^v;
      default: o = |v;
    endcase
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
        break;
      end
    end
  endfunction

  task automatic do_op(input int k, input logic [7:0] v, input logic [1:0] m,
                       input int stall, input string tag);
    logic       exp_o;
    logic [2:0] exp_i;
    int         lat;
    int         exp_lat;
    ref_model(v, m, exp_o, exp_i);
    exp_lat = (k == 0) ? 4 : 1;
    check({tag, ".in_ready_idle"}, in_ready[k], 1);
    din[k] = v;
    mode[k] = m;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'($urandom_range(0, 1));
    tick;
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 20) begin
      din[k] = 8'($urandom);
      mode[k] = 2'($urandom);
      in_valid[k] = 1'($urandom_range(0, 1));
      out_ready[k] = 1'($urandom_range(0, 1));
      tick;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".out"}, outv[k], exp_o);
    check({tag, ".out_idx"}, out_idx[k], exp_i);
    in_valid[k] = 1'b1;
    din[k] = 8'($urandom);
    mode[k] = 2'($urandom);
    out_ready[k] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick;
      check({tag, ".hold_valid"}, out_valid[k], 1);
      check({tag, ".hold_out"}, outv[k], exp_o);
      check({tag, ".hold_idx"}, out_idx[k], exp_i);
      check({tag, ".hold_in_ready"}, in_ready[k], 0);
    end
    out_ready[k] = 1'b1;
    tick;
    check({tag, ".released"}, out_valid[k], 0);
    check({tag, ".back_idle"}, in_ready[k], 1);
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[k] = '0;
      mode[k] = '0;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst.in_ready", in_ready[k], 1);
      check("rst.out_valid", out_valid[k], 0);
      check("rst.out", outv[k], 0);
      check("rst.out_idx", out_idx[k], 0);
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    do_op(0, 8'b00000000, 2'b00, 0, "or_zero");
    do_op(0, 8'b00110001, 2'b00, 0, "or_low");
    do_op(0, 8'b10000000, 2'b00, 0, "or_msb");
    do_op(0, 8'b11111111, 2'b01, 0, "and_ones");
    do_op(0, 8'b11101111, 2'b01, 0, "and_hole");
    do_op(0, 8'b00010011, 2'b10, 5, "xor_stall");
    do_op(1, 8'b00010000, 2'b11, 0, "rsvd_n1");

    // Abort an operation mid-BUSY: nothing may be presented afterwards.
    din[0] = 8'hFF;
    mode[0] = 2'b01;
    in_valid[0] = 1'b1;
    tick;
    in_valid[0] = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check("busy_rst.in_ready", in_ready[0], 1);
    check("busy_rst.out_valid", out_valid[0], 0);
    check("busy_rst.out", outv[0], 0);
    check("busy_rst.out_idx", out_idx[0], 0);
    tick;
    #2;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      check("busy_rst.no_result", out_valid[0], 0);
    end
    out_ready[0] = 1'b0;

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 2; k++) begin
        do_op(k, 8'($urandom), 2'($urandom), $urandom_range(0, 3), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
